fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a sync FIFO. The write word is registered, so it appears exactly 1 cycle after the beat is accepted.
// Ready falls combinationally on prog_full/fifo_full. The grant is held for the whole burst.
module fifo_wr_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 32,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          fifo_clk,
  input  logic                          fifo_sync_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          prog_full,
  output logic                          fifo_write,
  output logic [DATA_WIDTH+IDW-1:0]     fifo_input,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                      r_state;
  logic [NUM_REQ-1:0]          r_grant;
  logic [IDW-1:0]              r_owner;
  logic [IDW-1:0]              r_rr_ptr;
  logic                        r_fifo_write;
  logic [DATA_WIDTH+IDW-1:0]   r_fifo_input;

  logic                        w_flow_ok;
  logic                        w_accept;
  logic                        w_any;
  logic [IDW-1:0]              w_winner;
  logic [IDW:0]                w_idx;
  logic [DATA_WIDTH-1:0]       w_data;

  // Gating on reset keeps a beat from being handed off while the burst is being abandoned.
  assign w_flow_ok = fifo_sync_rst_n && !prog_full && !fifo_full;
  assign req_ready = (r_state == ST_BURST && w_flow_ok) ? r_grant : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_data    = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];

  // Descending scan so the first valid at or after rr_ptr (with wrap-around) is the one that sticks.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDW+1)'(NUM_REQ);
      end
      if (req_valid[w_idx[IDW-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (!fifo_sync_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_fifo_write <= 1'b0;
      r_fifo_input <= '0;
    end else begin
      r_fifo_write <= w_accept;
      if (w_accept) begin
        r_fifo_input <= {r_owner, w_data};
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any && !prog_full) begin
            r_state <= ST_BURST;
            r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
            r_owner <= w_winner;
          end
        end
        ST_BURST: begin
          if (w_accept && req_last[r_owner]) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == ST_BURST);
  assign grant      = r_grant;
  assign fifo_write = r_fifo_write;
  assign fifo_input = r_fifo_input;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter. A queue-based requester/FIFO reference model computes expected ready, grant and write words.
module tb_fifo_wr_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic              fifo_clk = 1'b0;
  logic              fifo_sync_rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              prog_full;
  logic              fifo_write;
  logic [DW+IDW-1:0] fifo_input;
  logic [NR-1:0]     grant;
  logic              busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .fifo_clk        (fifo_clk),
    .fifo_sync_rst_n (fifo_sync_rst_n),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .prog_full       (prog_full),
    .fifo_write      (fifo_write),
    .fifo_input      (fifo_input),
    .grant           (grant),
    .busy            (busy)
  );

  always #5 fifo_clk = ~fifo_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] bq [NR][$];
  bit          en [NR];
  int          gseq [NR];
  int          nseq [NR];
  int          m_owner;
  int          m_ptr;
  logic        m_wr;
  logic [DW+IDW-1:0] m_in;
  bit          fifo_mode;
  int          fcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Each requester's queued beats: bit 32 = last, data = {src, 8'hA5, seq}.
  task automatic add_burst(input int r, input int len);
    for (int b = 0; b < len; b++) begin
      bq[r].push_back({(b == len - 1), 8'(r), 8'hA5, 16'(gseq[r])});
      gseq[r]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && bq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = bq[i][0][32];
        req_data[i*DW +: DW] = bq[i][0][31:0];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic tick();
    logic [NR-1:0] m_rdy;
    logic [NR-1:0] eg;
    logic [32:0]   dummy;
    bit            acc;
    int            own;
    int            src;
    drive();
    if (fifo_mode) begin
      prog_full = (fcnt >= 7);
      fifo_full = (fcnt >= 8);
    end
    #1;
    own = m_owner;
    for (int i = 0; i < NR; i++) begin
      m_rdy[i] = fifo_sync_rst_n && (own == i) && !prog_full && !fifo_full;
    end
    chk("req_ready", req_ready, m_rdy);
    acc = 1'b0;
    if (own >= 0) acc = m_rdy[own] && req_valid[own];
    if (fifo_write) begin
      src = int'(fifo_input[DW+IDW-1:DW]);
      chk("src_order", fifo_input[15:0], nseq[src][15:0]);
      nseq[src]++;
    end
    if (fifo_mode) begin
      chk("no_wr_full", fifo_write && (fcnt >= 8), 0);
      if (fcnt > 0 && $urandom_range(0, 2) == 0) fcnt--;
      if (fifo_write && fcnt < 8) fcnt++;
    end
    if (!fifo_sync_rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_wr    = 1'b0;
      m_in    = '0;
    end else begin
      m_wr = acc;
      if (acc) begin
        m_in  = {IDW'(own), req_data[own*DW +: DW]};
        dummy = bq[own].pop_front();
      end
      if (own < 0) begin
        if (!prog_full) begin
          for (int k = 0; k < NR; k++) begin
            if (m_owner < 0 && req_valid[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
          end
        end
      end else if (acc && req_last[own]) begin
        m_ptr   = (own + 1) % NR;
        m_owner = -1;
      end
    end
    @(posedge fifo_clk);
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("fifo_write", fifo_write, m_wr);
    chk("fifo_input", fifo_input, m_in);
    chk("grant", grant, eg);
    chk("busy", busy, m_owner >= 0);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += bq[i].size();
    return s;
  endfunction

  initial begin
    logic [31:0] d0, d1, d2;
    logic [NR-1:0] prev;
    int ord[$];
    int wcnt;
    int guard;

    fifo_sync_rst_n = 1'b0;
    prog_full = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      en[i] = 1'b1; gseq[i] = 0; nseq[i] = 0;
    end
    m_owner = -1; m_ptr = 0; m_wr = 1'b0; m_in = '0;
    fifo_mode = 1'b0; fcnt = 0;

    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_write", fifo_write, 0);
    chk("rst_input", fifo_input, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    fifo_sync_rst_n = 1'b1;

    // Requesters 1 and 3 contend from rr_ptr=0
    add_burst(1, 3);
    add_burst(3, 1);
    d0 = bq[1][0][31:0]; d1 = bq[1][1][31:0]; d2 = bq[1][2][31:0];
    tick(); chk("032_grant", grant, 4'b0010);
    tick(); chk("032_d0", fifo_input, {2'd1, d0}); chk("032_wr0", fifo_write, 1);
    tick(); chk("032_d1", fifo_input, {2'd1, d1});
    tick(); chk("032_d2", fifo_input, {2'd1, d2}); chk("032_idle", grant, 0);
    tick(); chk("032_next", grant, 4'b1000);
    tick(); tick();

    // Continuous single-beat bursts from all four requesters
    for (int r = 0; r < NR; r++) begin add_burst(r, 1); add_burst(r, 1); end
    prev = '0; wcnt = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (fifo_write) wcnt++;
      if (grant != 0 && prev == 0) begin
        for (int i = 0; i < NR; i++) if (grant[i]) ord.push_back(i);
      end
      prev = grant;
    end
    chk("033_ngrant", ord.size(), 8);
    chk("033_writes", wcnt, 8);
    for (int k = 0; k < 5; k++) begin
      if (k < ord.size()) chk("033_order", ord[k], k % NR);
    end

    // prog_full raised mid-burst for 5 cycles
    add_burst(2, 6);
    tick(); tick();
    prog_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("034_wr_stall", fifo_write, 0);
      chk("034_rdy", req_ready, 0);
      chk("034_grant", grant, 4'b0100);
    end
    prog_full = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    chk("034_drained", bq[2].size(), 0);

    // Granted requester stalls while requester 3 waits
    en[3] = 1'b0;
    add_burst(0, 4);
    add_burst(3, 1);
    tick(); tick();
    en[0] = 1'b0; en[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("035_grant", grant, 4'b0001);
      chk("035_rdy3", req_ready[3], 0);
    end
    en[0] = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("035_drained", pending(), 0);

    // Move rr_ptr to 3, then reset during beat 2 of a 4-beat burst
    add_burst(2, 1);
    tick(); tick(); tick();
    add_burst(1, 4);
    tick(); tick();
    fifo_sync_rst_n = 1'b0;
    tick();
    chk("036_grant", grant, 0);
    chk("036_write", fifo_write, 0);
    chk("036_input", fifo_input, 0);
    chk("036_busy", busy, 0);
    fifo_sync_rst_n = 1'b1;
    bq[1].delete();
    nseq[1] = gseq[1];
    tick();
    chk("036_nowr", fifo_write, 0);
    add_burst(1, 1);
    add_burst(3, 1);
    tick();
    chk("036_ptr0", grant, 4'b0010);
    for (int c = 0; c < 6; c++) tick();

    // Random traffic into a depth-8 FIFO with prog_full at 7
    fifo_mode = 1'b1;
    fcnt = 0;
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (bq[r].size() < 2 && $urandom_range(0, 3) == 0) add_burst(r, $urandom_range(1, 4));
        en[r] = ($urandom_range(0, 4) != 0);
      end
      tick();
    end
    for (int r = 0; r < NR; r++) en[r] = 1'b1;
    guard = 0;
    while ((pending() > 0 || fifo_write) && guard < 600) begin
      tick();
      guard++;
    end
    chk("037_drained", pending(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
